// File: rtl/vcpu_pkg.sv
// Shared constants and types for the vector CPU front end.
package vcpu_pkg;
  localparam int          INSTR_W  = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [3:0]  HALT_OP  = 4'b1111;
  localparam int          HALT_HI  = 31;
  localparam int          HALT_LO  = 28;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_t;

  function automatic logic is_halt_word(input logic [31:0] w);
    return w[HALT_HI:HALT_LO] == HALT_OP;
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: branch redirect, then hold, then sequential +4.
module pc_next_sel #(
  parameter int I = 32
) (
  input  logic [I-1:0] pc_i,
  input  logic [I-1:0] pc_plus4_i,
  input  logic         branch_i,
  input  logic [I-1:0] target_i,
  input  logic         hold_i,
  output logic [I-1:0] pc_next_o
);
  always_comb begin
    pc_next_o = pc_plus4_i;
    if (branch_i)    pc_next_o = {target_i[I-1:2], 2'b00};
    else if (hold_i) pc_next_o = pc_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, squashes wrong-path words, parks on HALT.
module fetch_unit
  import vcpu_pkg::*;
#(
  parameter int          I        = INSTR_W,
  parameter logic [I-1:0] RESET_PC = '0,
  parameter logic [I-1:0] NOP      = NOP_WORD[I-1:0]
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallF,
  input  logic         BranchTakenE,
  input  logic [I-1:0] BranchTargetE,
  input  logic [I-1:0] InstrRD,
  output logic [I-1:0] PCF,
  output logic [I-1:0] PCPlus4F,
  output logic [I-1:0] InstrF,
  output logic         ValidF,
  output logic         HaltedF,
  output logic [31:0]  InstrCount
);
  fetch_state_t state_q, state_d;
  logic [I-1:0] pc_q, pc_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         run, halt_word, fetch_ok, hold;

  assign run       = (state_q == RUN);
  assign halt_word = is_halt_word(InstrRD[31:0]);
  // A word is accepted into the pipe only in RUN with no redirect pending.
  assign fetch_ok  = run && !BranchTakenE;
  assign hold      = !run || StallF || halt_word;

  assign PCF        = pc_q;
  assign PCPlus4F   = pc_q + I'(4);
  assign InstrF     = fetch_ok ? InstrRD : NOP;
  assign ValidF     = fetch_ok;
  assign HaltedF    = !run;
  assign InstrCount = cnt_q;

  pc_next_sel #(.I(I)) u_pc_next_sel (
    .pc_i      (pc_q),
    .pc_plus4_i(PCPlus4F),
    .branch_i  (BranchTakenE),
    .target_i  (BranchTargetE),
    .hold_i    (hold),
    .pc_next_o (pc_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (BranchTakenE) begin
      state_d = RUN;
    end else if (run && !StallF) begin
      if (halt_word) state_d = HALT;
      if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit, plus a wrap/reset-in-HALT instance.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, StallF, BranchTakenE;
  logic [31:0] BranchTargetE, InstrRD;
  logic [31:0] PCF, PCPlus4F, InstrF, InstrCount;
  logic        ValidF, HaltedF;

  logic        reset2;
  logic [31:0] InstrRD2, PCF2, PCPlus4F2, InstrF2, InstrCount2;
  logic        ValidF2, HaltedF2;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .StallF(StallF), .BranchTakenE(BranchTakenE),
    .BranchTargetE(BranchTargetE), .InstrRD(InstrRD), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .InstrF(InstrF), .ValidF(ValidF), .HaltedF(HaltedF), .InstrCount(InstrCount)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset2), .StallF(zero1), .BranchTakenE(zero1),
    .BranchTargetE(zero32), .InstrRD(InstrRD2), .PCF(PCF2), .PCPlus4F(PCPlus4F2),
    .InstrF(InstrF2), .ValidF(ValidF2), .HaltedF(HaltedF2), .InstrCount(InstrCount2)
  );

  typedef struct {
    logic        stall, br;
    logic [31:0] tgt, instr;
    logic [31:0] pc, instr_f, cnt;
    logic        valid, halted;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic stall, logic br, logic [31:0] tgt, logic [31:0] instr,
                              logic [31:0] pc, logic [31:0] instr_f, logic valid,
                              logic halted, logic [31:0] cnt);
    vec_t v;
    v.stall = stall; v.br = br; v.tgt = tgt; v.instr = instr;
    v.pc = pc; v.instr_f = instr_f; v.valid = valid; v.halted = halted; v.cnt = cnt;
    return v;
  endfunction

  localparam logic [31:0] ADD = 32'h4000_0000;
  localparam logic [31:0] HLT = 32'hF000_0000;

  initial begin
    // Expected values are the outputs seen before the edge that applies each row.
    vecs.push_back(mk(0, 0, 0,      ADD, 32'h00,  ADD, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,      ADD, 32'h04,  ADD, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0,      ADD, 32'h08,  ADD, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0,      ADD, 32'h08,  ADD, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0,      ADD, 32'h08,  ADD, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0,      ADD, 32'h0C,  ADD, 1, 0, 3));
    vecs.push_back(mk(0, 1, 32'h43, ADD, 32'h10,  0,   0, 0, 4));
    vecs.push_back(mk(0, 1, 32'h20, ADD, 32'h40,  0,   0, 0, 4));
    vecs.push_back(mk(0, 0, 0,      HLT, 32'h20,  HLT, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0,      HLT, 32'h20,  0,   0, 1, 5));
    vecs.push_back(mk(1, 0, 0,      HLT, 32'h20,  0,   0, 1, 5));
    vecs.push_back(mk(0, 0, 0,      ADD, 32'h20,  0,   0, 1, 5));
    vecs.push_back(mk(0, 0, 0,      HLT, 32'h20,  0,   0, 1, 5));
    vecs.push_back(mk(0, 0, 0,      HLT, 32'h20,  0,   0, 1, 5));
    vecs.push_back(mk(0, 1, 32'h80, HLT, 32'h20,  0,   0, 1, 5));
    vecs.push_back(mk(1, 1, 32'h100,HLT, 32'h80,  0,   0, 0, 5));
    vecs.push_back(mk(0, 0, 0,      ADD, 32'h100, ADD, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0,      ADD, 32'h104, ADD, 1, 0, 6));

    reset = 1; StallF = 0; BranchTakenE = 0; BranchTargetE = 0; InstrRD = ADD;
    reset2 = 1; InstrRD2 = ADD;
    tick(); tick();

    chk("rst_pc", PCF, 32'h0);
    chk("rst_cnt", InstrCount, 32'h0);
    chk("rst_halted", {31'b0, HaltedF}, 32'h0);
    chk("rst_valid", {31'b0, ValidF}, 32'h1);

    reset = 0;
    reset2 = 0;
    #1;
    // Wrap instance: reset value just below 2^32, first +4 wraps to zero.
    chk("wrap_rst_pc", PCF2, 32'hFFFF_FFFC);
    chk("wrap_plus4", PCPlus4F2, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      StallF = vecs[i].stall; BranchTakenE = vecs[i].br;
      BranchTargetE = vecs[i].tgt; InstrRD = vecs[i].instr;
      if (i == 1) InstrRD2 = HLT;
      #1;
      chk($sformatf("v%0d_pc", i), PCF, vecs[i].pc);
      chk($sformatf("v%0d_pc4", i), PCPlus4F, vecs[i].pc + 32'd4);
      chk($sformatf("v%0d_instr", i), InstrF, vecs[i].instr_f);
      chk($sformatf("v%0d_valid", i), {31'b0, ValidF}, {31'b0, vecs[i].valid});
      chk($sformatf("v%0d_halted", i), {31'b0, HaltedF}, {31'b0, vecs[i].halted});
      chk($sformatf("v%0d_cnt", i), InstrCount, vecs[i].cnt);
      if (i == 1) begin
        chk("wrap_pc_after_edge", PCF2, 32'h0);
        chk("wrap_cnt", InstrCount2, 32'h1);
      end
      tick();
    end

    // Wrap instance parked on HALT since the second row; now reset it mid-HALT.
    chk("wrap_halted", {31'b0, HaltedF2}, 32'h1);
    chk("wrap_halt_pc", PCF2, 32'h0);
    chk("wrap_halt_instr", InstrF2, 32'h0);
    reset2 = 1;
    tick();
    reset2 = 0;
    #1;
    chk("wrap_rst_halt_pc", PCF2, 32'hFFFF_FFFC);
    chk("wrap_rst_halt_halted", {31'b0, HaltedF2}, 32'h0);
    chk("wrap_rst_halt_cnt", InstrCount2, 32'h0);

    // Reset during a stall on the main instance.
    StallF = 1; reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rst_stall_pc", PCF, 32'h0);
    chk("rst_stall_cnt", InstrCount, 32'h0);
    StallF = 0;
    tick();
    chk("post_rst_pc", PCF, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the vector CPU. It sits directly upstream of segment_if_id and produces InstrF for it.
- Owns the program counter and drives the instruction-memory read address.
- Applies hazard stalls and taken-branch redirects from execute.
- Stops fetching on a HALT instruction and substitutes NOP bubbles until redirected or reset.

Parameters:
I, 32, instruction and PC width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP, 32'h0000_0000, bubble word emitted when no valid instruction is fetched.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
StallF  input  1  hazard-unit hold; PC and counter keep their values.
BranchTakenE  input  1  taken control-flow instruction resolved in execute.
BranchTargetE  input  I  redirect byte address; bits [1:0] are ignored (forced to 0).
InstrRD  input  I  instruction-memory read data for the current PCF (combinational ROM).
PCF  output  I  current fetch address, registered.
PCPlus4F  output  I  PCF+4, modulo 2^I.
InstrF  output  I  instruction to segment_if_id.
ValidF  output  1  InstrF is a real instruction, not a bubble.
HaltedF  output  1  high while the FSM is in HALT.
InstrCount  output  32  count of fetched valid instructions, saturating.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: PCF=RESET_PC, state=RUN, InstrCount=0. After reset, HaltedF=0, ValidF=1 and InstrF=InstrRD, because the outputs are combinational from the state.
- FSM states:
  - RUN: normal fetch.
  - HALT: PC frozen, bubbles emitted.
- HALT word: InstrRD[31:28]==4'b1111.
- Combinational outputs:
  - RUN and BranchTakenE=0: InstrF=InstrRD, ValidF=1.
  - Otherwise (HALT, or BranchTakenE=1): InstrF=NOP, ValidF=0, so the wrong-path word is squashed.
  - HaltedF=(state==HALT).
- Next-state and next-PC priority, evaluated at each rising edge, highest first:
  1. reset: PCF<=RESET_PC, state<=RUN, InstrCount<=0.
  2. BranchTakenE: PCF<={BranchTargetE[I-1:2],2'b00}, state<=RUN. This applies from HALT too, because a HALT fetched behind an older taken branch is speculative and is cancelled. StallF is ignored this cycle.
  3. state==HALT: hold everything.
  4. StallF: hold PCF, hold state, hold InstrCount. InstrF/ValidF still reflect InstrRD; segment_if_id holds its own register.
  5. RUN with a HALT word on InstrRD: state<=HALT, PCF holds. The HALT word itself is emitted with ValidF=1 that cycle and counted.
  6. Otherwise: PCF<=PCF+4.
- InstrCount increments by 1 only on an edge where all of the following hold:
  - state==RUN
  - BranchTakenE=0
  - StallF=0
  - reset=0

  It saturates at 32'hFFFF_FFFF.
- Latency: redirect takes effect 1 cycle after BranchTakenE is sampled, i.e. a 1-cycle bubble at fetch.
- Wrap: PC+4 wraps modulo 2^I with no error.
- Reset mid-HALT or mid-stall: the reset arm wins; RUN resumes in the next cycle.

Decomposition:
- Package vcpu_pkg:
  - I width constant.
  - NOP constant.
  - HALT opcode constant 4'b1111 with its field slice [31:28].
  - fetch_state_t enum {RUN, HALT}.
- Sub-module pc_next_sel: a pure combinational next-PC priority mux (branch / hold / +4). The fetch_unit top holds the PC register, FSM and counter.

Test Plan:
1. Reset, release, InstrRD=32'h4000_0000 constant -> PCF 0,4,8,12 on successive cycles; ValidF=1; InstrCount=3 after the third edge.
2. StallF=1 for 2 cycles at PCF=8 -> PCF stays 8 and InstrCount unchanged for 2 edges; then PCF=12.
3. At PCF=0x10, BranchTakenE=1, BranchTargetE=0x43 -> that cycle InstrF=NOP and ValidF=0; next edge PCF=0x40; InstrCount not incremented.
4. InstrRD=32'hF000_0000 at PCF=0x20 -> that cycle ValidF=1 and InstrF=32'hF000_0000; then HaltedF=1, PCF stays 0x20, InstrF=NOP for 5 cycles. BranchTakenE with target 0x80 -> HaltedF=0, PCF=0x80.
5. Same cycle BranchTakenE=1, StallF=1, HALT word on InstrRD -> branch wins: PCF=target, state RUN, no halt.
6. RESET_PC=32'hFFFF_FFFC -> after one edge PCF=0. Assert reset while in HALT -> PCF=RESET_PC and HaltedF=0 after the edge.
